// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared next-PC encodings, fetch constants and FSM state type.
package if_fetch_stage_pkg;
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_JREG   = 2'b11;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    typedef enum logic {FETCH_RUN, FETCH_HALT} fetchState_t;
endpackage

// File: rtl/if_fetch_stage_instr_mem.sv
// instr_mem: word-addressed instruction store, combinational read, synchronous loader write.
module instr_mem
    import if_fetch_stage_pkg::*;
#(
    parameter int WORDS = 256
) (
    input  logic        Clock,
    input  logic        writeEn,
    input  logic [31:0] writeAddr,
    input  logic [31:0] writeData,
    input  logic [31:0] readAddr,
    output logic [31:0] readData
);
    localparam int AW = $clog2(WORDS);
    localparam logic [31:0] LIMIT = 32'(WORDS * 4);
    logic [31:0] mem [WORDS];
    always_ff @(posedge Clock)
        if (writeEn && writeAddr < LIMIT)
            mem[writeAddr[AW+1:2]] <= writeData;
    // Addresses past the array fetch a NOP rather than aliasing.
    assign readData = (readAddr < LIMIT) ? mem[readAddr[AW+1:2]] : NOP_WORD;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, instruction fetch and IF/ID register with a RUN/HALT machine.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        Flush_IF,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] JumpRegTarget,
    input  logic        ImemWriteEn,
    input  logic [31:0] ImemWriteAddr,
    input  logic [31:0] ImemWriteData,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction_IFID,
    output logic [31:0] PCPlus4_IFID,
    output logic        Valid_IFID,
    output logic        Halted
);
    fetchState_t state, stateNext;
    logic [31:0] fetched, pcPlus4, pcNext, instrNext, pcPlus4Next;
    logic validNext, ifidLoad, haltFetch, bubble;

    instr_mem #(.WORDS(IMEM_WORDS)) imem (
        .Clock    (Clock),
        .writeEn  (ImemWriteEn),
        .writeAddr(ImemWriteAddr),
        .writeData(ImemWriteData),
        .readAddr (PC_out),
        .readData (fetched)
    );

    assign pcPlus4 = PC_out + 32'd4;
    // Halt only when the HALT word actually lands in IF/ID unflushed.
    assign haltFetch = state == FETCH_RUN && IFIDWrite && !Flush_IF && fetched == HALT_WORD;

    always_ff @(posedge Clock)
        if (Reset) state <= FETCH_RUN;
        else       state <= stateNext;

    always_comb stateNext = haltFetch ? FETCH_HALT : state;

    always_comb begin
        bubble      = Flush_IF || state == FETCH_HALT;
        ifidLoad    = Flush_IF || IFIDWrite;
        instrNext   = bubble ? NOP_WORD : fetched;
        pcPlus4Next = bubble ? 32'd0 : pcPlus4;
        validNext   = !bubble;
        pcNext      = !(state == FETCH_RUN && PCWrite && !haltFetch) ? PC_out :
                      PCSrc == PCSRC_BRANCH ? BranchTarget :
                      PCSrc == PCSRC_JUMP   ? JumpTarget :
                      PCSrc == PCSRC_JREG   ? JumpRegTarget : pcPlus4;
    end

    always_ff @(posedge Clock)
        if (Reset) begin
            PC_out           <= RESET_PC;
            Instruction_IFID <= NOP_WORD;
            PCPlus4_IFID     <= 32'd0;
            Valid_IFID       <= 1'b0;
        end else begin
            PC_out <= pcNext;
            if (ifidLoad) begin
                Instruction_IFID <= instrNext;
                PCPlus4_IFID     <= pcPlus4Next;
                Valid_IFID       <= validNext;
            end
        end

    assign Halted = state == FETCH_HALT;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scoreboard bench for the instruction-fetch stage.
module tb_if_fetch_stage;
    logic        Clock = 1'b0, Reset = 1'b1;
    logic        PCWrite = 1'b1, IFIDWrite = 1'b1, Flush_IF = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] BranchTarget = '0, JumpTarget = '0, JumpRegTarget = '0;
    logic        ImemWriteEn = 1'b0;
    logic [31:0] ImemWriteAddr = '0, ImemWriteData = '0;
    logic [31:0] PC_out, Instruction_IFID, PCPlus4_IFID;
    logic        Valid_IFID, Halted;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc, instr, p4;
        logic        valid, halted, chkP4;
    } exp_t;
    exp_t sb[$];

    if_fetch_stage dut (
        .Clock(Clock), .Reset(Reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .Flush_IF(Flush_IF), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .JumpTarget(JumpTarget), .JumpRegTarget(JumpRegTarget),
        .ImemWriteEn(ImemWriteEn), .ImemWriteAddr(ImemWriteAddr), .ImemWriteData(ImemWriteData),
        .PC_out(PC_out), .Instruction_IFID(Instruction_IFID), .PCPlus4_IFID(PCPlus4_IFID),
        .Valid_IFID(Valid_IFID), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compareHead();
        exp_t e = sb.pop_front();
        check({e.tag, ".pc"}, PC_out, e.pc);
        check({e.tag, ".instr"}, Instruction_IFID, e.instr);
        if (e.chkP4) check({e.tag, ".pcplus4"}, PCPlus4_IFID, e.p4);
        check({e.tag, ".valid"}, 32'(Valid_IFID), 32'(e.valid));
        check({e.tag, ".halted"}, 32'(Halted), 32'(e.halted));
    endtask

    task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] p4, input logic valid, input logic halted,
                        input logic chkP4 = 1'b1);
        exp_t e;
        e.tag = tag; e.pc = pc; e.instr = instr; e.p4 = p4;
        e.valid = valid; e.halted = halted; e.chkP4 = chkP4;
        sb.push_back(e);
        @(posedge Clock); #1;
        compareHead();
    endtask

    task automatic load(input int word, input logic [31:0] data);
        ImemWriteEn = 1'b1; ImemWriteAddr = 32'(word * 4); ImemWriteData = data;
        @(posedge Clock); #1;
        ImemWriteEn = 1'b0;
    endtask

    task automatic runDefaults();
        PCWrite = 1'b1; IFIDWrite = 1'b1; Flush_IF = 1'b0; PCSrc = 2'b00;
    endtask

    task automatic doReset();
        Reset = 1'b1; runDefaults();
        step("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        Reset = 1'b0;
    endtask

    initial begin
        #1;
        for (int i = 0; i < 5; i++) load(i, 32'h2008_0001 + 32'(i));
        load(5, 32'hFFFF_FFFF);
        load(16, 32'h2008_0011);
        load(17, 32'h2008_0012);
        load(20, 32'hFFFF_FFFF);
        doReset();

        step("seq0", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 1'b0);
        step("seq1", 32'h8, 32'h2008_0002, 32'h8, 1'b1, 1'b0);
        step("seq2", 32'hC, 32'h2008_0003, 32'hC, 1'b1, 1'b0);
        step("seq3", 32'h10, 32'h2008_0004, 32'h10, 1'b1, 1'b0);

        doReset();
        step("pre0", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 1'b0);
        step("pre1", 32'h8, 32'h2008_0002, 32'h8, 1'b1, 1'b0);
        PCWrite = 1'b0; IFIDWrite = 1'b0;
        for (int i = 0; i < 3; i++) step("stall", 32'h8, 32'h2008_0002, 32'h8, 1'b1, 1'b0);
        runDefaults();
        step("resume", 32'hC, 32'h2008_0003, 32'hC, 1'b1, 1'b0);

        doReset();
        step("j.pre", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 1'b0);
        PCSrc = 2'b10; JumpTarget = 32'h40; Flush_IF = 1'b1;
        step("j.flush", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        runDefaults();
        step("j.target", 32'h44, 32'h2008_0011, 32'h44, 1'b1, 1'b0);
        Flush_IF = 1'b1; IFIDWrite = 1'b0; PCWrite = 1'b0;
        step("flushhold", 32'h44, 32'h0, 32'h0, 1'b0, 1'b0);
        runDefaults();
        step("after", 32'h48, 32'h2008_0012, 32'h48, 1'b1, 1'b0);

        doReset();
        for (int i = 0; i < 5; i++)
            step("h.run", 32'(4 * (i + 1)), 32'h2008_0001 + 32'(i), 32'(4 * (i + 1)), 1'b1, 1'b0);
        step("h.latch", 32'h14, 32'hFFFF_FFFF, 32'h18, 1'b1, 1'b1);
        PCSrc = 2'b01; BranchTarget = 32'h0;
        step("h.frozen", 32'h14, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step("h.frozen2", 32'h14, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        doReset();

        PCSrc = 2'b10; JumpTarget = 32'h50; Flush_IF = 1'b1;
        step("fh.jump", 32'h50, 32'h0, 32'h0, 1'b0, 1'b0);
        JumpTarget = 32'hFFFF_FFFC;
        step("fh.squash", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
        runDefaults();
        step("wrap", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("wrap.next", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
